key_load_ctrl: RTL and testbench
================================

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 64, giving the number of key bits driven to XOR_g/XNOR_g key-gate inputs (range 2..1024).
REQ-002 SHALL have parameter FAIL_MAX, default 3, giving the consecutive parity failures that trigger lockout (range 1..15).
REQ-003 SHALL have port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port R, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new key load.
REQ-006 SHALL have port kbit, input, 1 bit: serial key/parity data.
REQ-007 SHALL have port kbit_vld, input, 1 bit: kbit qualifier; a bit is accepted only when kbit_vld=1 in SHIFT.
REQ-008 SHALL have port key_out, output, KEY_W bits: the applied key, driving the key-gate inputs.
REQ-009 SHALL have port key_valid, output, 1 bit: key_out holds a parity-checked key.
REQ-010 SHALL have port busy, output, 1 bit: high in SHIFT and CHECK.
REQ-011 SHALL have port err, output, 1 bit: the last load failed parity.
REQ-012 SHALL have port locked_out, output, 1 bit: lockout is active (KEY_LOCKOUT_EN builds only; tied 0 otherwise).

Function
REQ-013 SHALL implement states IDLE, SHIFT, CHECK, DONE, ERR and LOCKOUT, all registered.
REQ-014 IDLE/DONE/ERR with start=1 SHALL go to SHIFT next edge; in the same edge, clear the shift register and bit counter, and drive key_valid=0, err=0 and key_out=0.
REQ-015 In SHIFT, each accepted bit SHALL be shifted in MSB-first (shreg <= {shreg[KEY_W-2:0], kbit}) while the counter increments.
REQ-016 The (KEY_W+1)th accepted bit SHALL be captured as the parity bit (not shifted), and the FSM SHALL enter CHECK next edge.
REQ-017 Cycles with kbit_vld=0 in SHIFT SHALL hold all state; there is no timeout.
REQ-018 start in SHIFT or CHECK SHALL be ignored.
REQ-019 CHECK SHALL last exactly one cycle and compute even parity: XOR of shreg and the parity bit equal to 0 means pass.
REQ-020 On pass, the FSM SHALL go to DONE, load key_out <= shreg, set key_valid=1 and clear the fail counter.
REQ-021 On fail, the FSM SHALL go to ERR with err=1, key_out=0 and key_valid=0, and the fail counter SHALL increment (saturating at 15).
REQ-022 Latency SHALL be: last bit accepted at edge N, key_valid/err high after edge N+2.
REQ-023 key_out SHALL change only on a CHECK pass, on start, or on reset; it SHALL never expose partial shift contents.
REQ-024 The bit counter SHALL be $clog2(KEY_W+2) bits wide and SHALL never wrap within a load.
REQ-025 busy SHALL be registered and equal (state==SHIFT || state==CHECK).

Reset
REQ-026 R=0 SHALL asynchronously force IDLE, shreg=0, counter=0, parity bit=0, fail counter=0, key_out=0, key_valid=0, busy=0, err=0 and locked_out=0.
REQ-027 Reset asserted mid-SHIFT or mid-CHECK SHALL abort the load with no partial key applied; after release the block SHALL wait in IDLE for start.
REQ-028 Reset SHALL be the only exit from LOCKOUT.

Configuration
REQ-029 Macro KEY_LOCKOUT_EN defined: on entering ERR with the fail counter reaching FAIL_MAX, the FSM SHALL go to LOCKOUT the next edge; in LOCKOUT, locked_out=1, key_out=0, key_valid=0, err=1, and start is ignored.
REQ-030 Macro KEY_LOCKOUT_EN undefined: no LOCKOUT state or logic SHALL exist, locked_out SHALL be constant 0, and failures SHALL be unlimited (retry via start).

Verification
REQ-031 KEY_W=8: start, then bits 1,0,1,1,0,0,1,0 and parity 0 with kbit_vld=1 each cycle -> key_out=8'hB2 and key_valid=1 two edges after the parity bit; busy=0 from then.
REQ-032 Same key with parity 1 -> err=1, key_out=8'h00, key_valid=0; a following start with correct parity -> key_out=8'hB2 and err=0.
REQ-033 kbit_vld toggled 1,0,0,1,... during the load -> identical key_out to REQ-031; start pulsed mid-SHIFT -> no effect.
REQ-034 R pulsed low after 5 of 8 bits -> all outputs 0 immediately (asynchronously); a fresh load then succeeds normally.
REQ-035 KEY_LOCKOUT_EN defined, FAIL_MAX=3: three bad-parity loads -> locked_out=1 and a subsequent good load is ignored (key_valid stays 0); R low then high -> locked_out=0. Undefined build: the same stimulus -> the 4th (good) load passes.

Source files
------------

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader with parity check for XOR/XNOR key gates
//
// Purpose:
//   Shifts a KEY_W-bit key in MSB-first, followed by one even-parity bit.
//   A key that passes parity is applied on key_out; a failing load clears
//   key_out and raises err. key_out never shows partially shifted data.
//
// Optional feature (macro KEY_LOCKOUT_EN):
//   When defined, FAIL_MAX consecutive parity failures move the block into a
//   LOCKOUT state that only reset can leave. When undefined, failures are
//   unlimited and locked_out is tied low.
//
// Parameters:
//   KEY_W     number of key bits (2..1024)
//   FAIL_MAX  consecutive failures that trigger lockout (1..15)
//
// Ports:
//   C           clock, rising edge
//   R           asynchronous active-low reset
//   start       request a new key load (honoured in IDLE/DONE/ERR)
//   kbit        serial key/parity data
//   kbit_vld    kbit qualifier
//   key_out     applied key (KEY_W bits)
//   key_valid   key_out holds a parity-checked key
//   busy        high while in SHIFT or CHECK
//   err         last load failed parity
//   locked_out  lockout active (KEY_LOCKOUT_EN builds only)

module key_load_ctrl #(
  parameter int KEY_W    = 64,
  parameter int FAIL_MAX = 3
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             kbit,
  input  logic             kbit_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             locked_out
);

  // Elaboration-time parameter range guards.
  if (KEY_W < 2 || KEY_W > 1024) begin : g_bad_key_w
    $error("key_load_ctrl: KEY_W out of range");
  end
  if (FAIL_MAX < 1 || FAIL_MAX > 15) begin : g_bad_fail_max
    $error("key_load_ctrl: FAIL_MAX out of range");
  end

  localparam int CW = $clog2(KEY_W + 2);
  // Counter value at which the next accepted bit is the parity bit.
  localparam logic [CW-1:0] CNT_PAR  = CW'(KEY_W);
  // Counter value once key and parity are both captured.
  localparam logic [CW-1:0] CNT_FULL = CW'(KEY_W + 1);

`ifdef KEY_LOCKOUT_EN
  localparam logic [3:0] FAIL_LIM = 4'(FAIL_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CHECK   = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;
`endif

  state_t           state;
  state_t           next_state;
  logic [KEY_W-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_bit;
  logic [3:0]       fail_cnt;

  logic             accept;
  logic             load_start;
  logic             parity_ok;

  logic [KEY_W-1:0] key_out_d;
  logic             key_valid_d;
  logic             busy_d;
  logic             err_d;

  // Once the counter is full, further bits are ignored until CHECK.
  assign accept     = (state == S_SHIFT) && kbit_vld && (cnt != CNT_FULL);
  assign load_start = (next_state == S_SHIFT) && (state != S_SHIFT);
  assign parity_ok  = ~((^shreg) ^ par_bit);

  // State register
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) next_state = S_SHIFT;
      end
      S_ERR: begin
`ifdef KEY_LOCKOUT_EN
        if (fail_cnt >= FAIL_LIM) next_state = S_LOCKOUT;
        else if (start)           next_state = S_SHIFT;
`else
        if (start) next_state = S_SHIFT;
`endif
      end
      // The parity bit lands in one edge; CHECK is entered on the following
      // edge, giving two edges from the last accepted bit to the result.
      S_SHIFT: begin
        if (cnt == CNT_FULL) next_state = S_CHECK;
      end
      S_CHECK: begin
        next_state = parity_ok ? S_DONE : S_ERR;
      end
`ifdef KEY_LOCKOUT_EN
      S_LOCKOUT: begin
        next_state = S_LOCKOUT;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    key_out_d   = key_out;
    key_valid_d = (next_state == S_DONE);
    busy_d      = (next_state == S_SHIFT) || (next_state == S_CHECK);
    err_d       = (next_state == S_ERR);
`ifdef KEY_LOCKOUT_EN
    err_d       = err_d || (next_state == S_LOCKOUT);
`endif
    if (state == S_CHECK && next_state == S_DONE) begin
      key_out_d = shreg;
    end else if (load_start || next_state == S_ERR) begin
      key_out_d = '0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      shreg     <= '0;
      cnt       <= '0;
      par_bit   <= 1'b0;
      fail_cnt  <= 4'd0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      key_out   <= key_out_d;
      key_valid <= key_valid_d;
      busy      <= busy_d;
      err       <= err_d;

      if (load_start) begin
        shreg   <= '0;
        cnt     <= '0;
        par_bit <= 1'b0;
      end else if (accept) begin
        if (cnt == CNT_PAR) begin
          par_bit <= kbit;
        end else begin
          shreg <= {shreg[KEY_W-2:0], kbit};
        end
        cnt <= cnt + CW'(1);
      end

      if (state == S_CHECK) begin
        if (parity_ok)             fail_cnt <= 4'd0;
        else if (fail_cnt != 4'hF) fail_cnt <= fail_cnt + 4'd1;
      end
    end
  end

`ifdef KEY_LOCKOUT_EN
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      locked_out <= 1'b0;
    end else begin
      locked_out <= (next_state == S_LOCKOUT);
    end
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - scoreboard bench for key_load_ctrl (KEY_W=8)

module tb_key_load_ctrl;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       start = 1'b0;
  logic       kbit = 1'b0;
  logic       kbit_vld = 1'b0;
  logic [7:0] key_out;
  logic       key_valid;
  logic       busy;
  logic       err;
  logic       locked_out;

  key_load_ctrl #(.KEY_W(8), .FAIL_MAX(3)) dut (
    .C(C), .R(R), .start(start), .kbit(kbit), .kbit_vld(kbit_vld),
    .key_out(key_out), .key_valid(key_valid), .busy(busy), .err(err),
    .locked_out(locked_out)
  );

  always #5 C = ~C;

  int cyc = 0;
  always @(posedge C) cyc = cyc + 1;

  typedef struct {
    logic [7:0] key;
    logic       kv;
    logic       er;
    logic       lo;
    int         when;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is presented when key_valid or err rises.
  logic prev_ev = 1'b0;
  always @(negedge C) begin
    logic ev;
    exp_t e;
    ev = key_valid | err;
    if (ev && !prev_ev) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got key_out=%0h key_valid=%0b err=%0b expected no result",
                 key_out, key_valid, err);
      end else begin
        e = q.pop_front();
        check("key_out", 64'(key_out), 64'(e.key));
        check("flags_kv_err_lo", 64'({key_valid, err, locked_out}), 64'({e.kv, e.er, e.lo}));
        check("latency_edge", 64'(cyc), 64'(e.when));
      end
    end
    prev_ev = ev;
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // One load: start, 8 key bits MSB-first, parity bit. gaps inserts two
  // invalid cycles (with junk on kbit) after each key bit; mid_start pulses
  // start alongside the fourth key bit.
  task automatic load(input logic [7:0] key, input logic par, input bit gaps,
                      input bit mid_start, input bit expect_result, input bit exp_pass);
    int   n;
    exp_t e;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      kbit     = key[i];
      kbit_vld = 1'b1;
      if (mid_start && i == 4) start = 1'b1;
      tick();
      start = 1'b0;
      if (gaps) begin
        kbit_vld = 1'b0;
        kbit     = ~kbit;
        tick();
        tick();
      end
    end
    kbit     = par;
    kbit_vld = 1'b1;
    tick();
    n        = cyc;
    kbit_vld = 1'b0;
    kbit     = 1'b0;
    if (expect_result) begin
      e.key  = exp_pass ? key : 8'h00;
      e.kv   = exp_pass;
      e.er   = !exp_pass;
      e.lo   = 1'b0;
      e.when = n + 2;
      q.push_back(e);
    end
    repeat (4) tick();
  endtask

  initial begin
    // Reset state
    #2 R = 1'b0;
    #1;
    check("reset_key_out", 64'(key_out), 64'h0);
    check("reset_flags", 64'({key_valid, busy, err, locked_out}), 64'h0);
    repeat (2) tick();
    R = 1'b1;
    repeat (2) tick();
    check("idle_flags", 64'({key_valid, busy, err, locked_out}), 64'h0);

    // Basic good load: B2 has four ones, parity 0
    load(8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("busy_after_done", 64'(busy), 64'h0);

    // Bad parity then good retry
    load(8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("key_out_after_err", 64'(key_out), 64'h0);
    load(8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("err_after_retry", 64'(err), 64'h0);

    // Gapped kbit_vld and start pulsed mid-SHIFT
    load(8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Other key patterns
    load(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    load(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    load(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset after 5 of 8 bits
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      kbit     = 1'b1;
      kbit_vld = 1'b1;
      tick();
    end
    kbit_vld = 1'b0;
    check("busy_mid_shift", 64'(busy), 64'h1);
    #2 R = 1'b0;
    #1;
    check("async_rst_key_out", 64'(key_out), 64'h0);
    check("async_rst_flags", 64'({key_valid, busy, err, locked_out}), 64'h0);
    tick();
    R = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", 64'({key_valid, busy, err}), 64'h0);
    load(8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Three consecutive bad loads
    load(8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef KEY_LOCKOUT_EN
    check("locked_after_3", 64'({locked_out, err}), 64'h3);
    load(8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lockout_ignores_load", 64'({key_valid, busy, locked_out}), 64'h1);
    check("lockout_key_out", 64'(key_out), 64'h0);
    R = 1'b0;
    #1;
    check("lockout_cleared", 64'(locked_out), 64'h0);
    tick();
    R = 1'b1;
    tick();
`else
    check("no_lockout", 64'(locked_out), 64'h0);
    load(8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("fourth_load_key", 64'(key_out), 64'hB2);
`endif

    repeat (10) tick();
    check("results_pending", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound in case the design stalls the stimulus.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
